// File: rtl/xbf_pkg.sv
// xbf_pkg: shared definitions for the XBF framed sample link receiver.
//   SYNC_WORD        frame start marker
//   BEAM_* / LEN_*   header field positions
//   xbf_state_t      receive parser states
package xbf_pkg;

    localparam logic [15:0] SYNC_WORD = 16'hA5C3;

    localparam int BEAM_MSB = 15;
    localparam int BEAM_LSB = 12;
    localparam int LEN_MSB  = 11;
    localparam int LEN_LSB  = 0;

    typedef enum logic [1:0] {
        HUNT = 2'd0,
        HDR  = 2'd1,
        PAY  = 2'd2,
        CHK  = 2'd3
    } xbf_state_t;

endpackage

// File: rtl/xbf_frame_rx_hold.sv
// xbf_hold_reg: single-entry output register with valid/ready handshake and
// last/err sideband.
//   clk, rst            clock, async active-high reset
//   ld                  load a new word (caller guarantees slot is free or draining)
//   ld_data/last/err    word and sideband to load
//   ready               downstream accept
//   valid/data/last/err registered output word
module xbf_hold_reg #(
    parameter int DW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          ld,
    input  logic [DW-1:0] ld_data,
    input  logic          ld_last,
    input  logic          ld_err,
    input  logic          ready,
    output logic          valid,
    output logic [DW-1:0] data,
    output logic          last,
    output logic          err
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid <= 1'b0;
            data  <= '0;
            last  <= 1'b0;
            err   <= 1'b0;
        end else if (ld) begin
            valid <= 1'b1;
            data  <= ld_data;
            last  <= ld_last;
            err   <= ld_err;
        end else if (valid && ready) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/xbf_frame_rx.sv
// xbf_frame_rx: receive side of the XBF framed sample link.
// Parses SYNC, header (beam/length), payload and XOR checksum from a 16-bit
// word stream and forwards the payload with last/err/beam sideband.
//   clk, rst                       clock, async active-high reset
//   s_data/s_valid/s_ready         input word stream
//   m_data/m_valid/m_ready         payload output stream
//   m_last, m_err, m_beam          sideband (m_err meaningful with m_last)
//   frame_ok, frame_err            one-cycle frame status pulses
//   err_cnt                        saturating count of frame_err pulses
//
// state | meaning
// HUNT  | discard words until SYNC_WORD
// HDR   | expect header; latch beam/length, seed checksum
// PAY   | payload words; newest one is held back, previous one released
// CHK   | checksum word; release held word as last with verdict
module xbf_frame_rx #(
    parameter int              DW        = 16,
    parameter logic [DW-1:0]   SYNC_WORD = DW'(xbf_pkg::SYNC_WORD),
    parameter int              MAX_LEN   = 1024,
    parameter int              TIMEOUT   = 255
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [DW-1:0] s_data,
    input  logic          s_valid,
    output logic          s_ready,
    output logic [DW-1:0] m_data,
    output logic          m_valid,
    input  logic          m_ready,
    output logic          m_last,
    output logic [3:0]    m_beam,
    output logic          m_err,
    output logic          frame_ok,
    output logic          frame_err,
    output logic [15:0]   err_cnt
);
    import xbf_pkg::*;

    localparam int             LW        = LEN_MSB - LEN_LSB + 1;
    localparam int             TW        = $clog2(TIMEOUT + 1);
    localparam logic [LW:0]    MAX_LEN_C = MAX_LEN[LW:0];
    localparam logic [TW-1:0]  TMO_LOAD  = TW'(TIMEOUT - 1);

    xbf_state_t       state, state_nx;

    logic             acc, stall, tmo_fire, hdr_bad;
    logic [LW-1:0]    hdr_len;
    logic [3:0]       beam_q;
    logic [LW-1:0]    cnt_q;
    logic [DW-1:0]    chk_q, held_q;
    logic             held_v;
    logic [TW-1:0]    tmo_q;

    logic             ld, ld_last, ld_err, ok_set, err_set;

    // Output slot is free, or is being emptied this cycle.
    assign s_ready  = !m_valid || m_ready;
    assign acc      = s_valid && s_ready;
    assign stall    = m_valid && !m_ready;
    assign hdr_len  = s_data[LEN_MSB:LEN_LSB];
    assign hdr_bad  = (hdr_len == '0) || ({1'b0, hdr_len} > MAX_LEN_C);
    // Timer only runs down on idle cycles where the output is not stalled, so
    // a firing timeout always finds the output slot available.
    assign tmo_fire = (state != HUNT) && !acc && !stall && (tmo_q == '0);
    assign m_beam   = beam_q;

    always_comb begin
        state_nx = state;
        ld       = 1'b0;
        ld_last  = 1'b0;
        ld_err   = 1'b0;
        ok_set   = 1'b0;
        err_set  = 1'b0;
        case (state)
            HUNT: begin
                if (acc && s_data == SYNC_WORD) state_nx = HDR;
            end
            HDR: begin
                if (tmo_fire) begin
                    err_set  = 1'b1;
                    state_nx = HUNT;
                end else if (acc) begin
                    if (hdr_bad) begin
                        err_set  = 1'b1;
                        state_nx = HUNT;
                    end else begin
                        state_nx = PAY;
                    end
                end
            end
            PAY: begin
                if (tmo_fire) begin
                    ld       = held_v;
                    ld_last  = 1'b1;
                    ld_err   = 1'b1;
                    err_set  = 1'b1;
                    state_nx = HUNT;
                end else if (acc) begin
                    ld = held_v;
                    if (cnt_q == LW'(1)) state_nx = CHK;
                end
            end
            CHK: begin
                if (tmo_fire) begin
                    ld       = 1'b1;
                    ld_last  = 1'b1;
                    ld_err   = 1'b1;
                    err_set  = 1'b1;
                    state_nx = HUNT;
                end else if (acc) begin
                    ld       = 1'b1;
                    ld_last  = 1'b1;
                    ld_err   = (s_data != chk_q);
                    ok_set   = (s_data == chk_q);
                    err_set  = (s_data != chk_q);
                    state_nx = HUNT;
                end
            end
            default: state_nx = HUNT;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= HUNT;
        else     state <= state_nx;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tmo_q     <= TMO_LOAD;
            beam_q    <= '0;
            cnt_q     <= '0;
            chk_q     <= '0;
            held_q    <= '0;
            held_v    <= 1'b0;
            frame_ok  <= 1'b0;
            frame_err <= 1'b0;
            err_cnt   <= '0;
        end else begin
            if (state == HUNT || acc)
                tmo_q <= TMO_LOAD;
            else if (!stall && tmo_q != '0)
                tmo_q <= tmo_q - 1'b1;

            if (state == HDR && acc) begin
                beam_q <= s_data[BEAM_MSB:BEAM_LSB];
                cnt_q  <= hdr_len;
                chk_q  <= s_data;
            end

            if (state == PAY && acc) begin
                chk_q  <= chk_q ^ s_data;
                held_q <= s_data;
                held_v <= 1'b1;
                cnt_q  <= cnt_q - 1'b1;
            end

            if (state != HUNT && state_nx == HUNT) held_v <= 1'b0;

            frame_ok  <= ok_set;
            frame_err <= err_set;
            if (err_set && err_cnt != 16'hFFFF) err_cnt <= err_cnt + 16'd1;
        end
    end

    xbf_hold_reg #(.DW(DW)) u_hold (
        .clk     (clk),
        .rst     (rst),
        .ld      (ld),
        .ld_data (held_q),
        .ld_last (ld_last),
        .ld_err  (ld_err),
        .ready   (m_ready),
        .valid   (m_valid),
        .data    (m_data),
        .last    (m_last),
        .err     (m_err)
    );

endmodule

// File: tb/tb_xbf_frame_rx.sv
module tb_xbf_frame_rx;

    localparam int          TIMEOUT = 255;
    localparam int          MAX_LEN = 1024;
    localparam logic [15:0] SYNC    = 16'hA5C3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] s_data = '0;
    logic        s_valid = 1'b0;
    logic        s_ready;
    logic [15:0] m_data;
    logic        m_valid;
    logic        m_ready = 1'b0;
    logic        m_last;
    logic [3:0]  m_beam;
    logic        m_err;
    logic        frame_ok;
    logic        frame_err;
    logic [15:0] err_cnt;

    xbf_frame_rx dut (
        .clk       (clk),
        .rst       (rst),
        .s_data    (s_data),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .m_data    (m_data),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_last    (m_last),
        .m_beam    (m_beam),
        .m_err     (m_err),
        .frame_ok  (frame_ok),
        .frame_err (frame_err),
        .err_cnt   (err_cnt)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errs   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errs++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [15:0] d;
        logic        last;
        logic        err;
        logic [3:0]  beam;
    } word_t;

    // Reference model: frame parser over accepted words, expressed as
    // "parsing phase" plus the payload collected so far.
    word_t       expq[$];
    word_t       logq[$];
    int          phase = 0;        // 0 hunt, 1 header, 2 payload, 3 checksum
    logic [3:0]  mbeam = '0;
    int          mlen = 0;
    int          mcnt = 0;
    logic [15:0] mchk = '0;
    logic [15:0] mheld = '0;
    bit          mheld_v = 1'b0;
    int          idle = 0;
    bit          exp_ok = 1'b0;
    bit          exp_err = 1'b0;
    int          merrs = 0;
    int          ok_seen = 0;
    int          err_seen = 0;
    int          sready_low = 0;
    bit          prev_stall = 1'b0;
    logic [17:0] prev_out = '0;
    int          rdy_mode = 0;     // 0 always ready, 1 toggle, 2 random

    function automatic void push_exp(logic [15:0] d, bit l, bit e, logic [3:0] b);
        word_t w;
        w.d = d; w.last = l; w.err = e; w.beam = b;
        expq.push_back(w);
    endfunction

    function automatic void model_reset();
        expq.delete();
        phase = 0; mheld_v = 1'b0; idle = 0;
        exp_ok = 1'b0; exp_err = 1'b0; merrs = 0;
        prev_stall = 1'b0;
    endfunction

    function automatic void flag_err();
        exp_err = 1'b1;
        if (merrs < 65535) merrs++;
    endfunction

    function automatic void model_step(bit acc, bit stall, logic [15:0] w);
        exp_ok  = 1'b0;
        exp_err = 1'b0;
        if (phase != 0) begin
            if (acc) idle = 0;
            else if (!stall) idle++;
        end
        if (phase != 0 && !acc && idle == TIMEOUT) begin
            if (mheld_v) push_exp(mheld, 1'b1, 1'b1, mbeam);
            mheld_v = 1'b0;
            flag_err();
            phase = 0;
        end else if (acc) begin
            case (phase)
                0: if (w == SYNC) begin phase = 1; idle = 0; end
                1: begin
                    mbeam = w[15:12];
                    mlen  = int'(w[11:0]);
                    mchk  = w;
                    if (mlen == 0 || mlen > MAX_LEN) begin
                        flag_err();
                        phase = 0;
                    end else begin
                        mcnt  = 0;
                        phase = 2;
                    end
                end
                2: begin
                    mchk = mchk ^ w;
                    if (mheld_v) push_exp(mheld, 1'b0, 1'b0, mbeam);
                    mheld   = w;
                    mheld_v = 1'b1;
                    mcnt++;
                    if (mcnt == mlen) phase = 3;
                end
                default: begin
                    push_exp(mheld, 1'b1, (w != mchk), mbeam);
                    mheld_v = 1'b0;
                    if (w == mchk) exp_ok = 1'b1;
                    else flag_err();
                    phase = 0;
                end
            endcase
        end
    endfunction

    // Compare process: inputs and outputs only change right after posedge,
    // so negedge values are exactly what the next posedge will see.
    initial begin
        word_t e, a;
        forever begin
            @(negedge clk);
            if (rst) begin
                model_reset();
            end else begin
                check("frame_ok", 32'(frame_ok), 32'(exp_ok));
                check("frame_err", 32'(frame_err), 32'(exp_err));
                check("err_cnt", 32'(err_cnt), 32'(merrs));
                check("s_ready", 32'(s_ready), 32'(!m_valid || m_ready));
                if (frame_ok)  ok_seen++;
                if (frame_err) err_seen++;
                if (m_valid && !s_ready) sready_low++;
                if (prev_stall) begin
                    check("stall_valid", 32'(m_valid), 32'd1);
                    check("stall_hold", 32'({m_data, m_last, m_err}), 32'(prev_out));
                end
                if (m_valid && m_ready) begin
                    a.d = m_data; a.last = m_last; a.err = m_err; a.beam = m_beam;
                    logq.push_back(a);
                    if (expq.size() == 0) begin
                        n_checks++;
                        n_errs++;
                        $display("FAIL unexpected_word: got %0h, want no word", m_data);
                    end else begin
                        e = expq.pop_front();
                        check("m_data", 32'(m_data), 32'(e.d));
                        check("m_last", 32'(m_last), 32'(e.last));
                        check("m_beam", 32'(m_beam), 32'(e.beam));
                        if (e.last) check("m_err", 32'(m_err), 32'(e.err));
                    end
                end
                prev_stall = m_valid && !m_ready;
                prev_out   = {m_data, m_last, m_err};
                model_step(s_valid && s_ready, m_valid && !m_ready, s_data);
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0:       m_ready = 1'b1;
                1:       m_ready = ~m_ready;
                default: m_ready = ($urandom_range(0, 3) != 0);
            endcase
        end
    end

    logic [15:0] txq[$];

    task automatic send_word(input logic [15:0] w);
        int  k;
        bit  done;
        s_valid = 1'b1;
        s_data  = w;
        k = 0;
        done = 1'b0;
        while (!done) begin
            @(negedge clk);
            if (s_ready) done = 1'b1;
            else begin
                k++;
                if (k > 5000) begin
                    n_checks++;
                    n_errs++;
                    $display("FAIL send_timeout: got s_ready=0 for %0d cycles, want accept", k);
                    done = 1'b1;
                end
            end
        end
        @(posedge clk);
        #1;
        s_valid = 1'b0;
        s_data  = 16'($urandom);
    endtask

    task automatic send_txq(input bit gaps);
        for (int i = 0; i < txq.size(); i++) begin
            if (gaps) repeat ($urandom_range(0, 2)) @(posedge clk);
            if (gaps) #1;
            send_word(txq[i]);
        end
        txq.delete();
    endtask

    task automatic gen_frame(input logic [3:0] beam, input logic [11:0] len, input bit corrupt);
        logic [15:0] hdr, chk, w;
        hdr = {beam, len};
        chk = hdr;
        txq.push_back(SYNC);
        txq.push_back(hdr);
        if (len != 12'd0 && int'(len) <= MAX_LEN) begin
            for (int i = 0; i < int'(len); i++) begin
                w = ($urandom_range(0, 7) == 0) ? SYNC : 16'($urandom);
                chk = chk ^ w;
                txq.push_back(w);
            end
            if (corrupt) chk = chk ^ (16'd1 << $urandom_range(0, 15));
            txq.push_back(chk);
        end
    endtask

    task automatic wait_drain();
        int  k;
        bit  done;
        k = 0;
        done = 1'b0;
        while (!done) begin
            @(negedge clk);
            if (phase == 0 && expq.size() == 0 && !m_valid) done = 1'b1;
            else begin
                k++;
                if (k > 3000) begin
                    n_checks++;
                    n_errs++;
                    $display("FAIL drain_timeout: got %0d words pending, want 0", expq.size());
                    done = 1'b1;
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_m_valid"}, 32'(m_valid), 32'd0);
        check({tag, "_m_data"}, 32'({m_data, m_last, m_err, m_beam}), 32'd0);
        check({tag, "_pulses"}, 32'({frame_ok, frame_err}), 32'd0);
        check({tag, "_err_cnt"}, 32'(err_cnt), 32'd0);
        check({tag, "_s_ready"}, 32'(s_ready), 32'd1);
    endtask

    task automatic check_good_log(input string tag, input int base);
        check({tag, "_count"}, 32'(logq.size() - base), 32'd3);
        if (logq.size() >= base + 3) begin
            check({tag, "_w0"}, 32'({logq[base].d, logq[base].last}), 32'h0000_0002);
            check({tag, "_w1"}, 32'({logq[base+1].d, logq[base+1].last}), 32'h0000_0004);
            check({tag, "_w2"}, 32'({logq[base+2].d, logq[base+2].last, logq[base+2].err}), 32'h0000_0012);
            check({tag, "_beam"}, 32'(logq[base+2].beam), 32'd3);
        end
    endtask

    initial begin
        int base, ok0, err0, c;
        bit seen;
        logic [11:0] len;

        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_idle_outputs("reset");
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Good frame, always ready.
        rdy_mode = 0;
        base = logq.size(); ok0 = ok_seen;
        txq = '{16'hA5C3, 16'h3003, 16'h0001, 16'h0002, 16'h0004, 16'h3004};
        send_txq(1'b0);
        wait_drain();
        check_good_log("good", base);
        check("good_ok_pulses", 32'(ok_seen - ok0), 32'd1);

        // Bad checksum.
        base = logq.size(); err0 = err_seen;
        txq = '{16'hA5C3, 16'h3003, 16'h0001, 16'h0002, 16'h0004, 16'h3005};
        send_txq(1'b0);
        wait_drain();
        check("badchk_count", 32'(logq.size() - base), 32'd3);
        if (logq.size() >= base + 3)
            check("badchk_last", 32'({logq[base+2].d, logq[base+2].last, logq[base+2].err}), 32'h0000_0013);
        check("badchk_err_pulses", 32'(err_seen - err0), 32'd1);
        check("badchk_err_cnt", 32'(err_cnt), 32'd1);

        // Zero length, then a good frame.
        base = logq.size(); ok0 = ok_seen; err0 = err_seen;
        txq = '{16'hA5C3, 16'h5000};
        send_txq(1'b0);
        wait_drain();
        check("len0_no_output", 32'(logq.size() - base), 32'd0);
        check("len0_err_pulses", 32'(err_seen - err0), 32'd1);
        txq = '{16'hA5C3, 16'h3003, 16'h0001, 16'h0002, 16'h0004, 16'h3004};
        send_txq(1'b0);
        wait_drain();
        check_good_log("after_len0", base);
        check("after_len0_ok", 32'(ok_seen - ok0), 32'd1);

        // Backpressure: m_ready toggling.
        rdy_mode = 1;
        base = logq.size(); c = sready_low;
        txq = '{16'hA5C3, 16'h3003, 16'h0001, 16'h0002, 16'h0004, 16'h3004};
        send_txq(1'b0);
        wait_drain();
        check_good_log("bp", base);
        check("bp_sready_low_seen", 32'(sready_low > c), 32'd1);

        // Timeout mid-payload: 255 idle cycles before the abort.
        rdy_mode = 0;
        @(posedge clk);
        #1;
        err0 = err_seen;
        txq = '{16'hA5C3, 16'h1002, 16'h00AA};
        send_txq(1'b0);
        c = 0; seen = 1'b0;
        for (int i = 1; i <= 300; i++) begin
            @(posedge clk);
            #1;
            if (!seen && m_valid) begin
                seen = 1'b1;
                c = i;
                check("tmo_word", 32'({m_data, m_last, m_err}), 32'h0000_02AB);
                check("tmo_frame_err", 32'(frame_err), 32'd1);
            end
        end
        check("tmo_seen", 32'(seen), 32'd1);
        check("tmo_cycles", 32'(c), 32'd255);
        check("tmo_err_pulses", 32'(err_seen - err0), 32'd1);
        wait_drain();

        // Garbage before sync, then async reset mid-payload.
        txq = '{16'h1234, 16'hFFFF, 16'hA5C3, 16'h2004, 16'h0011, 16'h0022};
        send_txq(1'b0);
        @(posedge clk);
        #3;
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_idle_outputs("midrst");
        @(posedge clk);
        #1;
        rst = 1'b0;
        check_idle_outputs("postrst");
        base = logq.size(); ok0 = ok_seen;
        txq = '{16'hA5C3, 16'h3003, 16'h0001, 16'h0002, 16'h0004, 16'h3004};
        send_txq(1'b0);
        wait_drain();
        check_good_log("postrst", base);
        check("postrst_ok", 32'(ok_seen - ok0), 32'd1);

        // Randomized frames with garbage, gaps, bad lengths and backpressure.
        rdy_mode = 2;
        for (int f = 0; f < 40; f++) begin
            if ($urandom_range(0, 3) == 0) begin
                txq.push_back(16'h0F0F ^ 16'($urandom_range(0, 255)));
                send_txq(1'b1);
            end
            c = $urandom_range(0, 9);
            if (c == 0)      len = 12'h000;
            else if (c == 1) len = 12'h401;
            else if (c == 2) len = 12'hFFF;
            else             len = 12'($urandom_range(1, 6));
            gen_frame(4'($urandom_range(0, 15)), len, ($urandom_range(0, 3) == 0));
            send_txq(1'b1);
        end
        wait_drain();

        // Longest legal frame.
        ok0 = ok_seen;
        gen_frame(4'hA, 12'h400, 1'b0);
        send_txq(1'b0);
        wait_drain();
        check("maxlen_ok", 32'(ok_seen - ok0), 32'd1);

        rdy_mode = 0;
        repeat (4) @(posedge clk);
        #1;
        check("final_queue_empty", 32'(expq.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule

// File: doc/xbf_frame_rx.md
Name: xbf_frame_rx

Overview:
- Receive side of the XBF framed sample link. Parses a 16-bit word stream carrying sync, header, payload and checksum.
- Forwards the payload as a stream with a last-word marker, beam id and frame error flag.
- Sits between the link input and the beam-data consumers inside XBF_Top. It mirrors the frame transmitter that builds the same format.

Parameters:
- DW, 16, word width; fixed frame format assumes 16.
- SYNC_WORD, 16'hA5C3, frame start marker.
- MAX_LEN, 1024, maximum payload words per frame.
- TIMEOUT, 255, idle cycles tolerated mid-frame before abort.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- s_data  in  DW  input word.
- s_valid  in  1  input word valid.
- s_ready  out  1  input accept.
- m_data  out  DW  payload word.
- m_valid  out  1  output valid.
- m_ready  in  1  output accept.
- m_last  out  1  last payload word of frame.
- m_beam  out  4  beam id of current frame.
- m_err  out  1  frame error; meaningful only with m_last.
- frame_ok  out  1  one-cycle pulse per good frame.
- frame_err  out  1  one-cycle pulse per bad or aborted frame.
- err_cnt  out  16  saturating count of frame_err pulses.

Behaviour:
- Interface: one clock; reset is asynchronous and active-high, ports clk and rst.
- Reset values: all outputs 0, except s_ready, which is 1 after reset. FSM = HUNT; checksum, length and timeout registers cleared.
- Input handshake: a word transfers when s_valid && s_ready. s_ready = !hold_valid || (m_valid && m_ready).
- Output handshake:
  - m_data/m_last/m_err stay stable while m_valid && !m_ready.
  - A word is accepted when m_valid && m_ready.
- Frame format:
  - SYNC_WORD.
  - Header: [15:12] beam id, [11:0] length N.
  - N payload words.
  - Checksum = XOR of header and all payload words.
- FSM states:
  - HUNT: words other than SYNC_WORD are discarded silently. SYNC_WORD -> HDR.
  - HDR: latch beam and N; chk <= header.
    - N==0 or N>MAX_LEN: frame_err pulse, -> HUNT.
    - Otherwise: -> PAY.
  - PAY: chk ^= word; count words.
    - Each payload word enters a one-word hold register.
    - The previous held word is released to the output with m_last=0.
    - After word N -> CHK. Word N stays held and is not presented yet.
  - CHK:
    - Received word == chk: release the held word with m_last=1, m_err=0, and pulse frame_ok.
    - Otherwise: release it with m_last=1, m_err=1, and pulse frame_err.
    - -> HUNT.
- Latency: payload word k appears on m_data once word k+1 (or the checksum) is accepted. It is valid the cycle after that acceptance.
- Timeout:
  - In HDR/PAY/CHK, count cycles with no accepted input, and only while the output is not stalled.
  - Counter reaches TIMEOUT: any held word is released with m_last=1, m_err=1; frame_err pulses; -> HUNT.
  - Timeout during HDR emits no output word.
- SYNC_WORD value inside payload or checksum is treated as data; there is no resync.
- m_beam is constant from header to the frame's m_last transfer.
- err_cnt saturates at 16'hFFFF.
- Reset mid-frame clears everything. No partial m_last is generated.
- Simultaneous input accept and output accept in the same cycle is legal and sustains 1 word/cycle throughput.

Decomposition:
- Package xbf_pkg holds:
  - SYNC_WORD constant.
  - Header field positions (BEAM_MSB/LSB, LEN_MSB/LSB).
  - FSM state enum: HUNT, HDR, PAY, CHK.
- One natural sub-module: xbf_hold_reg, the single-entry output register with valid/ready and last/err sideband.

Test Plan:
- Good frame: A5C3, 3003, 0001, 0002, 0004, chk 3004 with m_ready=1 -> m_data 0001, 0002, 0004; m_last on 0004; m_beam=3; m_err=0; one frame_ok.
- Bad checksum: same frame with chk 3005 -> three payload words out, last word has m_err=1, frame_err pulses, err_cnt=1.
- Length zero: A5C3, 5000 -> no output, frame_err pulse, FSM back in HUNT; following good frame received correctly.
- Backpressure: good frame with m_ready toggling 1/0 each cycle -> data held stable while stalled, s_ready deasserts while hold register full, output sequence unchanged.
- Timeout: A5C3, 1002, 00AA, then s_valid=0 for 300 cycles -> 00AA emitted with m_last=1, m_err=1 after 255 idle cycles; frame_err pulses.
- Garbage before sync (1234, FFFF) and async reset asserted mid-PAY -> garbage discarded; after reset all outputs 0 and next frame parses cleanly.
